sync_sr_bank: RTL and testbench

- N-channel bank of clocked SR flags driven by asynchronous S/R inputs.
- Each channel does three things:
  - Synchronises its S/R pair through a multi-stage flop chain.
  - Filters out pulses shorter than a programmable number of clocks.
  - Runs a per-channel state machine that produces Q/notQ, with a configurable policy for the S=R=1 condition.
- Sits at the boundary between external asynchronous controls (buttons, sensors) and synchronous logic. It is the clocked, multi-channel successor to the single asynchronous SR gate.

---
 rtl/sr_bank_pkg.sv | 42 ++++
 rtl/sync_filter.sv | 68 ++++++
 rtl/sync_sr_bank.sv | 79 +++++++
 tb/tb_sync_sr_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared types and constants for the sync_sr_bank channel bank.
//   sr_state_t  : per-channel flag state (UNDEF, SET, CLR, ILLEGAL)
//   sr_pair_t   : accepted {S,R} request pair
//   MODE_*      : policy for the S=R=1 request
//   next_state(): state transition on an accepted pair
package sr_bank_pkg;

    typedef enum logic [1:0] {
        UNDEF   = 2'd0,
        SET     = 2'd1,
        CLR     = 2'd2,
        ILLEGAL = 2'd3
    } sr_state_t;

    typedef struct packed {
        logic s;
        logic r;
    } sr_pair_t;

    localparam int unsigned MODE_INVALID = 0;
    localparam int unsigned MODE_SET_DOM = 1;
    localparam int unsigned MODE_RST_DOM = 2;

    function automatic sr_state_t next_state(input sr_state_t   cur,
                                             input sr_pair_t    fp,
                                             input int unsigned mode);
        sr_state_t nxt;
        nxt = cur;
        case ({fp.s, fp.r})
            2'b10:   nxt = SET;
            2'b01:   nxt = CLR;
            2'b11: begin
                if (mode == MODE_SET_DOM)      nxt = SET;
                else if (mode == MODE_RST_DOM) nxt = CLR;
                else                           nxt = ILLEGAL;
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_filter.sv
// One channel's input conditioning: an S and an R synchroniser chain
// followed by a persistence filter on the synchronised pair.
//   clk     : system clock, rising edge
//   nReset  : asynchronous active-low reset
//   i_s     : asynchronous set request
//   i_r     : asynchronous reset request
//   o_fp    : accepted pair {s,r}; changes only after the synchronised pair
//             has been stable and different for FILTER consecutive clocks
module sync_filter
    import sr_bank_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 2
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       i_s,
    input  logic       i_r,
    output logic [1:0] o_fp
);

    localparam int unsigned CW = $clog2(FILTER + 1);

    logic [SYNC_STAGES-1:0] r_s_sync;
    logic [SYNC_STAGES-1:0] r_r_sync;
    sr_pair_t               r_fp;
    sr_pair_t               r_cand;
    logic [CW-1:0]          r_cnt;

    sr_pair_t               w_sync;
    logic [CW-1:0]          w_cnt_next;

    assign w_sync.s = r_s_sync[SYNC_STAGES-1];
    assign w_sync.r = r_r_sync[SYNC_STAGES-1];

    // A zero count means no candidate is being timed, so r_cand is stale
    // and the count restarts at 1 just as it does when the pair changes.
    always_comb begin
        w_cnt_next = CW'(1);
        if ((r_cnt != '0) && (w_sync == r_cand))
            w_cnt_next = r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_s_sync <= '0;
            r_r_sync <= '0;
            r_fp     <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
        end else begin
            r_s_sync <= {r_s_sync[SYNC_STAGES-2:0], i_s};
            r_r_sync <= {r_r_sync[SYNC_STAGES-2:0], i_r};
            if (w_sync == r_fp) begin
                r_cnt <= '0;
            end else if (w_cnt_next == CW'(FILTER)) begin
                r_fp  <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cand <= w_sync;
                r_cnt  <= w_cnt_next;
            end
        end
    end

    assign o_fp = r_fp;

endmodule

// File: rtl/sync_sr_bank.sv
// N-channel bank of clocked SR flags fed by asynchronous S/R requests.
// Each channel synchronises and filters its request pair, then runs a
// small state machine whose registered outputs drive Q/notQ.
//   clk     : system clock, rising edge
//   nReset  : asynchronous active-low reset
//   S, R    : asynchronous set/reset requests, one bit per channel
//   err_clr : synchronous pulse clearing every sticky err bit
//   Q, notQ : registered flag and complement (0/0 when UNDEF or ILLEGAL)
//   err     : sticky per-channel S=R=1 flag (MODE_INVALID only)
module sync_sr_bank
    import sr_bank_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER      = 2,
    parameter int unsigned MODE        = 0
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic [N-1:0] S,
    input  logic [N-1:0] R,
    input  logic         err_clr,
    output logic [N-1:0] Q,
    output logic [N-1:0] notQ,
    output logic [N-1:0] err
);

    sr_pair_t  w_fp    [N];
    sr_state_t r_state [N];
    logic [N-1:0] r_q;
    logic [N-1:0] r_nq;
    logic [N-1:0] r_err;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [1:0] w_fp_raw;

        sync_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER      (FILTER)
        ) u_sync_filter (
            .clk    (clk),
            .nReset (nReset),
            .i_s    (S[g]),
            .i_r    (R[g]),
            .o_fp   (w_fp_raw)
        );

        assign w_fp[g] = sr_pair_t'(w_fp_raw);
    end

    // Q/notQ are decoded from the next state so they land on the same edge
    // as the state register rather than one clock later.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int unsigned i = 0; i < N; i++) r_state[i] <= UNDEF;
            r_q   <= '0;
            r_nq  <= '0;
            r_err <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                sr_state_t nxt;
                nxt        = next_state(r_state[i], w_fp[i], MODE);
                r_state[i] <= nxt;
                r_q[i]     <= (nxt == SET);
                r_nq[i]    <= (nxt == CLR);
                // Setting takes priority over a coincident err_clr.
                if ((MODE == MODE_INVALID) && w_fp[i].s && w_fp[i].r)
                    r_err[i] <= 1'b1;
                else if (err_clr)
                    r_err[i] <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign notQ = r_nq;
    assign err  = r_err;

endmodule

// File: tb/tb_sync_sr_bank.sv
module tb_sync_sr_bank;

    localparam int unsigned N = 4;

    logic         clk;
    logic         nReset;
    logic [N-1:0] S;
    logic [N-1:0] R;
    logic         err_clr;

    logic [N-1:0] q0, nq0, e0;
    logic [N-1:0] q1, nq1, e1;
    logic [N-1:0] q2, nq2, e2;

    int unsigned n_checks;
    int unsigned n_fail;

    sync_sr_bank #(.N(N), .SYNC_STAGES(2), .FILTER(2), .MODE(0)) u_dut0 (
        .clk(clk), .nReset(nReset), .S(S), .R(R), .err_clr(err_clr),
        .Q(q0), .notQ(nq0), .err(e0)
    );
    sync_sr_bank #(.N(N), .SYNC_STAGES(2), .FILTER(2), .MODE(1)) u_dut1 (
        .clk(clk), .nReset(nReset), .S(S), .R(R), .err_clr(err_clr),
        .Q(q1), .notQ(nq1), .err(e1)
    );
    sync_sr_bank #(.N(N), .SYNC_STAGES(2), .FILTER(2), .MODE(2)) u_dut2 (
        .clk(clk), .nReset(nReset), .S(S), .R(R), .err_clr(err_clr),
        .Q(q2), .notQ(nq2), .err(e2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance past k posedges and settle 1 time unit after the last one.
    task automatic edges(input int unsigned k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nReset   = 1'b1;
        S        = '0;
        R        = '0;
        err_clr  = 1'b0;

        // Asynchronous reset with everything requested, before any clock edge
        #1;
        nReset = 1'b0;
        S      = 4'hF;
        R      = 4'hF;
        #1;
        check("rst_q_async",   {28'd0, q0}, 32'h0);
        check("rst_nq_async",  {28'd0, nq0}, 32'h0);
        check("rst_err_async", {28'd0, e0}, 32'h0);
        edges(3);
        check("rst_q_held",   {28'd0, q0}, 32'h0);
        check("rst_err_held", {28'd0, e0}, 32'h0);

        @(negedge clk);
        S      = '0;
        R      = '0;
        nReset = 1'b1;
        edges(8);
        check("undef_q",  {28'd0, q0}, 32'h0);
        check("undef_nq", {28'd0, nq0}, 32'h0);

        // Channel 0: set lands exactly on edge 4 (edges 0..4 = 5 posedges)
        @(negedge clk);
        S[0] = 1'b1;
        edges(4);
        check("set0_edge3_q", {31'd0, q0[0]}, 32'h0);
        edges(1);
        check("set0_edge4_q",  {31'd0, q0[0]}, 32'h1);
        check("set0_edge4_nq", {31'd0, nq0[0]}, 32'h0);
        check("set0_others_q",  {29'd0, q0[3:1]}, 32'h0);
        check("set0_others_nq", {29'd0, nq0[3:1]}, 32'h0);

        @(negedge clk);
        S[0] = 1'b0;
        edges(6);
        check("hold0_q", {31'd0, q0[0]}, 32'h1);

        @(negedge clk);
        R[0] = 1'b1;
        edges(4);
        check("clr0_edge3_q", {31'd0, q0[0]}, 32'h1);
        edges(1);
        check("clr0_edge4_q",  {31'd0, q0[0]}, 32'h0);
        check("clr0_edge4_nq", {31'd0, nq0[0]}, 32'h1);
        @(negedge clk);
        R[0] = 1'b0;
        edges(6);

        // Channel 1: one-clock pulse rejected, two-clock pulse accepted
        @(negedge clk);
        S[1] = 1'b1;
        @(negedge clk);
        S[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            check("glitch1_q",  {31'd0, q0[1]}, 32'h0);
        end
        check("glitch1_nq", {31'd0, nq0[1]}, 32'h0);

        @(negedge clk);
        S[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        S[1] = 1'b0;
        edges(8);
        check("pulse2_q", {31'd0, q0[1]}, 32'h1);

        // Channel 2: S=R=1 under each policy
        @(negedge clk);
        S[2] = 1'b1;
        R[2] = 1'b1;
        edges(6);
        check("ill2_m0_q",   {31'd0, q0[2]}, 32'h0);
        check("ill2_m0_nq",  {31'd0, nq0[2]}, 32'h0);
        check("ill2_m0_err", {31'd0, e0[2]}, 32'h1);
        check("ill2_m1_q",   {31'd0, q1[2]}, 32'h1);
        check("ill2_m1_err", {28'd0, e1}, 32'h0);
        check("ill2_m2_q",   {31'd0, q2[2]}, 32'h0);
        check("ill2_m2_nq",  {31'd0, nq2[2]}, 32'h1);
        check("ill2_m2_err", {28'd0, e2}, 32'h0);
        check("ill2_m0_err_other", {28'd0, e0 & 4'b1011}, 32'h0);

        @(negedge clk);
        S[2] = 1'b0;
        R[2] = 1'b0;
        edges(6);
        check("ill2_hold_q",   {31'd0, q0[2]}, 32'h0);
        check("ill2_hold_nq",  {31'd0, nq0[2]}, 32'h0);
        check("ill2_hold_err", {31'd0, e0[2]}, 32'h1);

        @(negedge clk);
        R[2] = 1'b1;
        edges(6);
        check("ill2_exit_q",   {31'd0, q0[2]}, 32'h0);
        check("ill2_exit_nq",  {31'd0, nq0[2]}, 32'h1);
        check("ill2_exit_err", {31'd0, e0[2]}, 32'h1);
        @(negedge clk);
        R[2] = 1'b0;
        edges(6);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr_err", {31'd0, e0[2]}, 32'h0);
        check("errclr_nq",  {31'd0, nq0[2]}, 32'h1);

        // err_clr coinciding with entry into ILLEGAL: set wins on edge 4
        @(negedge clk);
        S[2] = 1'b1;
        R[2] = 1'b1;
        edges(4);
        check("setwins_pre_err", {31'd0, e0[2]}, 32'h0);
        @(negedge clk);
        err_clr = 1'b1;
        edges(1);
        check("setwins_err", {31'd0, e0[2]}, 32'h1);
        @(negedge clk);
        err_clr = 1'b0;
        S[2]    = 1'b0;
        R[2]    = 1'b0;
        edges(6);

        // Channel 3: reset in the middle of the filter count
        @(negedge clk);
        S[3] = 1'b1;
        edges(3);
        @(negedge clk);
        nReset = 1'b0;
        #1;
        check("midrst_q",   {28'd0, q0}, 32'h0);
        check("midrst_nq",  {28'd0, nq0}, 32'h0);
        check("midrst_err", {28'd0, e0}, 32'h0);
        @(negedge clk);
        nReset = 1'b1;
        edges(4);
        check("recov3_edge3_q", {31'd0, q0[3]}, 32'h0);
        edges(1);
        check("recov3_edge4_q",  {31'd0, q0[3]}, 32'h1);
        check("recov3_edge4_nq", {31'd0, nq0[3]}, 32'h0);
        check("recov_others_q",  {29'd0, q0[2:0]}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
